// File: rtl/immediate_encoder_if.sv
// Request/result bundle for the immediate encoder.
// master = requester, slave = encoder.
interface immediate_encoder_if;
  logic        start;
  logic [31:0] value;
  logic        ready;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] shiftOperand;

  modport master (
    output start, value,
    input  ready, busy, done, found, shiftOperand
  );

  modport slave (
    input  start, value,
    output ready, busy, done, found, shiftOperand
  );
endinterface

// File: rtl/immediate_encoder.sv
// Multi-cycle search for the {rot,imm8} operand-2 encoding of a
// 32-bit constant; LANES rotations are tried per SEARCH cycle.
module immediate_encoder #(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  immediate_encoder_if.slave bus
);

  localparam int         NG   = 16 / LANES;
  localparam logic [3:0] LAST = 4'(NG - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_val;
  logic [3:0]  r_grp;
  logic        r_found;
  logic [11:0] r_shop;

  logic        w_ready;
  logic        w_busy;
  logic        w_done;
  logic        w_hit;
  logic [3:0]  w_r;
  logic [7:0]  w_imm;
  logic [31:0] w_tmp;
  logic        w_acc;

  function automatic logic [31:0] rol2(
    input logic [31:0] x,
    input logic [3:0]  r
  );
    logic [63:0] t;
    t = {x, x} << {r, 1'b0};
    return t[63:32];
  endfunction

  function automatic logic [3:0] lane_r(
    input logic [3:0] g,
    input int         l
  );
    int t;
    t = int'(g) * LANES + l;
    return t[3:0];
  endfunction

  assign w_acc = (r_state == S_IDLE) && bus.start;

  // Walk lanes high to low so the lowest hit wins.
  always_comb begin
    w_hit = 1'b0;
    w_r   = 4'd0;
    w_imm = 8'd0;
    w_tmp = 32'd0;
    for (int l = LANES - 1; l >= 0; l--) begin
      w_tmp = rol2(r_val, lane_r(r_grp, l));
      if (w_tmp[31:8] == 24'd0) begin
        w_hit = 1'b1;
        w_r   = lane_r(r_grp, l);
        w_imm = w_tmp[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.start) w_next = S_SEARCH;
      S_SEARCH: if (w_hit || r_grp == LAST) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE:   w_ready = 1'b1;
      S_SEARCH: w_busy  = 1'b1;
      S_DONE:   w_done  = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= 32'd0;
      r_grp   <= 4'd0;
      r_found <= 1'b0;
      r_shop  <= 12'd0;
    end else if (w_acc) begin
      r_val   <= bus.value;
      r_grp   <= 4'd0;
      r_found <= 1'b0;
      r_shop  <= 12'd0;
    end else if (r_state == S_SEARCH) begin
      if (w_hit) begin
        r_found <= 1'b1;
        r_shop  <= {w_r, w_imm};
      end else if (r_grp == LAST) begin
        r_found <= 1'b0;
        r_shop  <= 12'd0;
      end else begin
        r_grp <= r_grp + 4'd1;
      end
    end
  end

  assign bus.ready        = w_ready;
  assign bus.busy         = w_busy;
  assign bus.done         = w_done;
  assign bus.found        = r_found;
  assign bus.shiftOperand = r_shop;

endmodule
